// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment readers and decoders.
//   DEFAULT_NUM_DIGITS : default number of multiplexed digits on a display
//   SEG_PATTERNS       : active-high segment patterns (bit6=a .. bit0=g),
//                        indexed by the hex digit they draw
package seg7_pkg;

   localparam int DEFAULT_NUM_DIGITS = 4;

   // Leftmost entry is digit F, rightmost is digit 0
   localparam logic [15:0][6:0] SEG_PATTERNS = {
      7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
      7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
   };

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// seg7_pattern_to_hex
// Combinational reverse lookup of a seven-segment pattern to its hex digit.
//   i_pattern : active-high segments, bit6=a .. bit0=g
//   o_nibble  : matching hex digit, 0 when nothing matches
//   o_hit     : 1 when the pattern is one of the sixteen known glyphs
module seg7_pattern_to_hex
   import seg7_pkg::*;
(
   input  logic [6:0] i_pattern,
   output logic [3:0] o_nibble,
   output logic       o_hit
);

   // Search the glyph table; an unlit (all-zero) pattern never matches,
   // so a blanked digit comes out as a miss
   always_comb begin
      o_nibble = 4'h0;
      o_hit    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i_pattern == SEG_PATTERNS[i]) begin
            o_nibble = 4'(i);
            o_hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
// Watches the pins of a multiplexed seven-segment display and rebuilds the
// number it shows, one complete frame at a time.
//   clk         : rising-edge system clock
//   reset       : synchronous active-high reset
//   seg_n       : active-low segments, bit6=a .. bit0=g
//   an_n        : active-low digit strobes, bit i low selects digit i
//   value       : last complete frame, nibble i = digit i
//   frame_valid : one-cycle pulse when value updates
//   bad_pattern : the delivered frame held at least one undecodable glyph
module seg7_scan_reader
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = DEFAULT_NUM_DIGITS,
   parameter int STABLE_CYCLES = 3
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic                    frame_valid,
   output logic                    bad_pattern
);

   localparam int            CW         = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

   logic [6:0]              r_segSample;
   logic [NUM_DIGITS-1:0]   r_anSample;
   logic [6:0]              r_segPrev;
   logic [NUM_DIGITS-1:0]   r_anPrev;
   logic [CW-1:0]           r_runCount;
   logic [4*NUM_DIGITS-1:0] r_pending;
   logic [NUM_DIGITS-1:0]   r_seen;
   logic                    r_pendBad;
   logic [4*NUM_DIGITS-1:0] r_value;
   logic                    r_frameValid;
   logic                    r_badPattern;

   logic                    w_selected;
   logic                    w_sameRun;
   logic [CW-1:0]           w_nextCount;
   logic                    w_capture;
   logic                    w_frameDone;
   logic [3:0]              w_nibble;
   logic                    w_hit;

   // The display pins come from another clock domain's logic, so every
   // decision is made on a registered copy; the previous copy is kept to
   // detect whether the pins held still for another cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_segSample <= '0;
         r_anSample  <= '0;
         r_segPrev   <= '0;
         r_anPrev    <= '0;
      end else begin
         r_segSample <= seg_n;
         r_anSample  <= an_n;
         r_segPrev   <= r_segSample;
         r_anPrev    <= r_anSample;
      end
   end

   // A sample only counts when exactly one strobe is active. The run
   // length restarts on any change and saturates, and the capture fires
   // on the single edge a run first reaches full length (a fresh run of
   // length one also qualifies when only one stable cycle is demanded)
   always_comb begin
      w_selected  = $onehot(~r_anSample);
      w_sameRun   = w_selected && (r_segSample == r_segPrev) && (r_anSample == r_anPrev);
      w_nextCount = '0;
      if (w_selected) begin
         if (!w_sameRun)
            w_nextCount = CW'(1);
         else if (r_runCount == STABLE_MAX)
            w_nextCount = STABLE_MAX;
         else
            w_nextCount = r_runCount + CW'(1);
      end
      w_capture   = (w_nextCount == STABLE_MAX) && !(w_sameRun && (r_runCount == STABLE_MAX));
      w_frameDone = &r_seen;
   end

   seg7_pattern_to_hex u_decode (
      .i_pattern (~r_segSample),
      .o_nibble  (w_nibble),
      .o_hit     (w_hit)
   );

   // Run-length counter for the current strobe/segment combination
   always_ff @(posedge clk) begin
      if (reset)
         r_runCount <= '0;
      else
         r_runCount <= w_nextCount;
   end

   // Frame assembly: a completed frame is published one edge after the
   // last digit is seen. A capture on that same edge lands after the
   // clear, so it becomes the first digit of the following frame while
   // the outgoing frame still publishes the old slot contents
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending    <= '0;
         r_seen       <= '0;
         r_pendBad    <= 1'b0;
         r_value      <= '0;
         r_frameValid <= 1'b0;
         r_badPattern <= 1'b0;
      end else begin
         r_frameValid <= 1'b0;
         if (w_frameDone) begin
            r_value      <= r_pending;
            r_badPattern <= r_pendBad;
            r_frameValid <= 1'b1;
            r_seen       <= '0;
            r_pendBad    <= 1'b0;
         end
         if (w_capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (!r_anSample[i]) begin
                  r_pending[4*i +: 4] <= w_nibble;
                  r_seen[i]           <= 1'b1;
               end
            end
            r_pendBad <= (r_pendBad && !w_frameDone) || !w_hit;
         end
      end
   end

   assign value       = r_value;
   assign frame_valid = r_frameValid;
   assign bad_pattern = r_badPattern;

endmodule
